// File: rtl/kalman_pkg.sv
// Shared types and constants for the Kalman frame sequencer.
//   seq_state_t            : sequencer FSM state encoding
//   TimeoutCyclesDefault   : default watchdog limit for one WAIT state
package kalman_pkg;

  localparam int unsigned TimeoutCyclesDefault = 64;

  typedef enum logic [2:0] {
    StIdle,
    StStartRp,
    StWaitRp,
    StStartYaw,
    StWaitYaw,
    StDone
  } seq_state_t;

endpackage

// File: rtl/flex_counter.sv
// Synchronous up-counter with clear, enable and programmable rollover.
// Counts 0,1,..,rollover_val, then wraps to 1. Clear has priority over enable.
//   clk_i            : clock
//   n_rst_i          : synchronous active-low reset
//   clear_i          : force count to 0
//   count_enable_i   : advance count
//   rollover_val_i   : terminal count
//   count_o          : current count
//   rollover_flag_o  : count_o equals rollover_val_i
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk_i,
  input  logic                    n_rst_i,
  input  logic                    clear_i,
  input  logic                    count_enable_i,
  input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
  output logic [NUM_CNT_BITS-1:0] count_o,
  output logic                    rollover_flag_o
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_enable_i) begin
      if (count_q == rollover_val_i) count_d = NUM_CNT_BITS'(1);
      else                           count_d = count_q + NUM_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o         = count_q;
  assign rollover_flag_o = (count_q == rollover_val_i);

endmodule

// File: rtl/kalman_sequencer.sv
// Frame-level controller in front of control_timer: per IMU sample it runs the
// roll/pitch pass, then the yaw pass, then presents a valid/ack result.
// One sample can be buffered; overrun and watchdog timeout are sticky flags.
//   clk_i, n_rst_i        : clock, synchronous active-low reset
//   sample_valid_i        : new IMU sample pulse
//   kalman_done_i         : pass finished (level may linger)
//   result_ack_i          : downstream consumed the result
//   clear_o               : timer counter clear
//   roll_pitch_enable_o   : start roll/pitch pass
//   yaw_enable_o          : start yaw pass
//   load_rp_o, load_yaw_o : latch strobes for each estimate
//   result_valid_o        : frame result ready, held until ack
//   frame_count_o         : completed frames, wrapping
//   overrun_o, timeout_o  : sticky error flags
module kalman_sequencer
  import kalman_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault,
  parameter int unsigned FRAME_CNT_BITS = 8
) (
  input  logic                      clk_i,
  input  logic                      n_rst_i,
  input  logic                      sample_valid_i,
  input  logic                      kalman_done_i,
  input  logic                      result_ack_i,
  output logic                      clear_o,
  output logic                      roll_pitch_enable_o,
  output logic                      yaw_enable_o,
  output logic                      load_rp_o,
  output logic                      load_yaw_o,
  output logic                      result_valid_o,
  output logic [FRAME_CNT_BITS-1:0] frame_count_o,
  output logic                      overrun_o,
  output logic                      timeout_o
);

  localparam int unsigned WdBits = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WdBits-1:0] WdLast = WdBits'(TIMEOUT_CYCLES - 1);

  seq_state_t state_q, state_d;
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic timeout_q, timeout_d;
  logic load_rp_q, load_rp_d;
  logic load_yaw_q, load_yaw_d;
  logic abort_clr_q, abort_clr_d;
  logic [FRAME_CNT_BITS-1:0] frame_q, frame_d;

  logic              wd_clear, wd_enable, wd_expired, done_seen;
  logic [WdBits-1:0] wd_count;

  assign wd_clear  = (state_q == StStartRp) || (state_q == StStartYaw);
  assign wd_enable = (state_q == StWaitRp) || (state_q == StWaitYaw);

  flex_counter #(
    .NUM_CNT_BITS(WdBits)
  ) u_watchdog (
    .clk_i           (clk_i),
    .n_rst_i         (n_rst_i),
    .clear_i         (wd_clear),
    .count_enable_i  (wd_enable),
    .rollover_val_i  (WdLast),
    .count_o         (wd_count),
    .rollover_flag_o (wd_expired)
  );

  // Watchdog reads 0 on the first WAIT cycle, so a done level left over from
  // the previous pass cannot end the new one.
  assign done_seen = kalman_done_i && (wd_count != '0);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;
    load_rp_d   = 1'b0;
    load_yaw_d  = 1'b0;
    abort_clr_d = 1'b0;
    frame_d     = frame_q;

    case (state_q)
      StIdle: begin
        if (sample_valid_i || pending_q) begin
          state_d   = StStartRp;
          // Starting on the buffered sample while a new one arrives: the new
          // one takes the buffer slot.
          pending_d = sample_valid_i && pending_q;
        end
      end
      StStartRp: state_d = StWaitRp;
      StWaitRp: begin
        if (done_seen) begin
          state_d   = StStartYaw;
          load_rp_d = 1'b1;
        end else if (wd_expired) begin
          state_d     = StIdle;
          timeout_d   = 1'b1;
          abort_clr_d = 1'b1;
        end
      end
      StStartYaw: state_d = StWaitYaw;
      StWaitYaw: begin
        if (done_seen) begin
          state_d    = StDone;
          load_yaw_d = 1'b1;
          frame_d    = frame_q + FRAME_CNT_BITS'(1);
        end else if (wd_expired) begin
          state_d     = StIdle;
          timeout_d   = 1'b1;
          abort_clr_d = 1'b1;
        end
      end
      StDone: begin
        if (result_ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (sample_valid_i && (state_q != StIdle)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      load_rp_q   <= 1'b0;
      load_yaw_q  <= 1'b0;
      abort_clr_q <= 1'b0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      load_rp_q   <= load_rp_d;
      load_yaw_q  <= load_yaw_d;
      abort_clr_q <= abort_clr_d;
      frame_q     <= frame_d;
    end
  end

  assign clear_o             = wd_clear || abort_clr_q;
  assign roll_pitch_enable_o = (state_q == StStartRp);
  assign yaw_enable_o        = (state_q == StStartYaw);
  assign load_rp_o           = load_rp_q;
  assign load_yaw_o          = load_yaw_q;
  assign result_valid_o      = (state_q == StDone);
  assign frame_count_o       = frame_q;
  assign overrun_o           = overrun_q;
  assign timeout_o           = timeout_q;

endmodule

// File: tb/tb_kalman_sequencer.sv
// Directed bench for kalman_sequencer with a behavioural control_timer stub.
module tb_kalman_sequencer;
  import kalman_pkg::*;

  localparam int unsigned DoneLat = 11;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       sample_valid = 1'b0;
  logic       result_ack = 1'b0;
  logic       kalman_done;
  logic       clear, rpe, yawe, load_rp, load_yaw, rv, overrun, timeout;
  logic [7:0] frame;

  int n_cmp = 0;
  int n_bad = 0;

  // Timer stub: 0 = nominal, 1 = done stuck low, 2 = done stuck high.
  int         stub_mode = 0;
  logic [4:0] tmr;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!n_rst)                 tmr <= '0;
    else if (rpe || yawe)       tmr <= 5'd1;
    else if (tmr != 0 && tmr < 15) tmr <= tmr + 5'd1;
  end

  assign kalman_done = (stub_mode == 2) ? 1'b1 :
                       (stub_mode == 1) ? 1'b0 : (tmr == 5'(DoneLat));

  kalman_sequencer dut (
    .clk_i               (clk),
    .n_rst_i             (n_rst),
    .sample_valid_i      (sample_valid),
    .kalman_done_i       (kalman_done),
    .result_ack_i        (result_ack),
    .clear_o             (clear),
    .roll_pitch_enable_o (rpe),
    .yaw_enable_o        (yawe),
    .load_rp_o           (load_rp),
    .load_yaw_o          (load_yaw),
    .result_valid_o      (rv),
    .frame_count_o       (frame),
    .overrun_o           (overrun),
    .timeout_o           (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_sample();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic ack_once();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  function automatic logic [31:0] flags();
    return {24'd0, clear, rpe, yawe, load_rp, load_yaw, rv, overrun, timeout};
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int misses;
    int k;

    // Reset
    step(2);
    chk("reset_flags", flags(), 32'd0);
    chk("reset_frame", 32'(frame), 32'd0);
    n_rst = 1'b1;
    tick();

    // Nominal frame A
    pulse_sample();                              // t0: START_RP
    chk("nom_rpe", {30'd0, rpe, clear}, 32'd3);
    tick();                                      // t1
    chk("nom_rpe_pulse", 32'(rpe), 32'd0);
    step(10);                                    // t11
    chk("nom_no_early_load_rp", 32'(load_rp), 32'd0);
    tick();                                      // t12: START_YAW
    chk("nom_load_rp_yaw_en", {29'd0, load_rp, yawe, clear}, 32'd7);
    tick();                                      // t13
    chk("nom_strobes_drop", {30'd0, load_rp, yawe}, 32'd0);
    step(11);                                    // t24: DONE
    chk("nom_load_yaw_rv", {30'd0, load_yaw, rv}, 32'd3);
    chk("nom_frame1", 32'(frame), 32'd1);

    // Ack hold
    step(20);
    chk("hold_rv", {30'd0, load_yaw, rv}, 32'd1);
    ack_once();
    chk("ack_rv_low", 32'(rv), 32'd0);
    chk("ack_idle", 32'(dut.state_q), 32'(StIdle));

    // Frame B with a buffered second sample
    pulse_sample();                              // b0
    tick();                                      // b1: WAIT_RP
    pulse_sample();                              // b2
    chk("buf_no_overrun", 32'(overrun), 32'd0);
    step(22);                                    // b24
    chk("buf_rv", 32'(rv), 32'd1);
    chk("buf_frame2", 32'(frame), 32'd2);
    ack_once();
    chk("buf_ack_idle", 32'(dut.state_q), 32'(StIdle));
    tick();                                      // c0: pending frame starts
    chk("buf_next_starts", 32'(rpe), 32'd1);
    chk("buf_still_no_overrun", 32'(overrun), 32'd0);

    // Frame C: two samples in WAIT_RP -> overrun
    tick();                                      // c1
    pulse_sample();                              // c2: pending
    pulse_sample();                              // c3: dropped
    chk("ovr_set", 32'(overrun), 32'd1);
    step(21);                                    // c24
    chk("ovr_frame3", {31'd0, rv}, 32'd1);
    chk("ovr_frame3_cnt", 32'(frame), 32'd3);
    ack_once();
    stub_mode = 1;
    tick();                                      // u0: buffered sample starts frame D
    chk("to_start", 32'(rpe), 32'd1);

    // Frame D: timer never finishes
    step(64);                                    // u64
    chk("to_not_yet", 32'(timeout), 32'd0);
    chk("to_wait_rp", 32'(dut.state_q), 32'(StWaitRp));
    tick();                                      // u65
    chk("to_flags", {29'd0, clear, rv, timeout}, 32'd5);
    chk("to_idle", 32'(dut.state_q), 32'(StIdle));
    chk("to_frame_same", 32'(frame), 32'd3);
    tick();
    chk("to_clear_pulse", {30'd0, clear, timeout}, 32'd1);
    stub_mode = 0;

    // Frame E: done held high across START_YAW
    pulse_sample();                              // v0
    step(11);                                    // v11: done naturally high
    stub_mode = 2;
    tick();                                      // v12
    chk("stale_load_rp", {30'd0, load_rp, yawe}, 32'd3);
    tick();                                      // v13: first WAIT_YAW cycle
    chk("stale_ignored1", {30'd0, load_yaw, rv}, 32'd0);
    tick();                                      // v14
    chk("stale_ignored2", {30'd0, load_yaw, rv}, 32'd0);
    tick();                                      // v15
    chk("stale_end", {30'd0, load_yaw, rv}, 32'd3);
    chk("stale_frame4", 32'(frame), 32'd4);
    stub_mode = 0;
    ack_once();

    // Reset mid WAIT_YAW
    pulse_sample();                              // w0
    step(14);
    chk("rst_in_wait_yaw", 32'(dut.state_q), 32'(StWaitYaw));
    n_rst = 1'b0;
    tick();
    chk("rst_mid_flags", flags(), 32'd0);
    chk("rst_mid_frame", 32'(frame), 32'd0);
    n_rst = 1'b1;
    tick();

    // 256 frames -> wrap
    misses = 0;
    for (int i = 1; i <= 256; i++) begin
      pulse_sample();
      k = 0;
      while (!rv && k < 100) begin
        tick();
        k++;
      end
      if (!rv) misses++;
      if (i == 255) chk("wrap_255", 32'(frame), 32'd255);
      ack_once();
    end
    chk("wrap_all_valid", 32'(misses), 32'd0);
    chk("wrap_zero", 32'(frame), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
